// File: rtl/nand_stim_seq_pkg.sv
// Shared types and constants for the NAND-chain stimulus sequencer and its golden model.
package nand_stim_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DRIVE     = 3'd1,
      ST_SAMPLE    = 3'd2,
      ST_REPORT    = 3'd3,
      ST_WAIT_STEP = 3'd4,
      ST_DONE      = 3'd5
   } seq_state_e;

   localparam int unsigned DEFAULT_HOLD = 4;
   localparam int unsigned HOLD_W       = 8;
   localparam int unsigned IDX_W        = 4;
   localparam int unsigned CNT_W        = 5;

   localparam logic [IDX_W-1:0] LAST_VEC = 4'd15;
   localparam logic [CNT_W-1:0] MISM_MAX = 5'd16;

   // Layout of one reported result; packs to {vecIdx, e, f, g, mismatch}.
   typedef struct packed {
      logic [IDX_W-1:0] vecIdx;
      logic [2:0]       efg;
      logic             mismatch;
   } res_word_t;

endpackage

// File: rtl/nand_golden.sv
// Combinational reference for the three-stage NAND chain: e=~(a&b), f=~(e&c), g=~(f&d).
module nand_golden (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic e,
   output logic f,
   output logic g
);

   assign e = ~(a & b);
   assign f = ~(e & c);
   assign g = ~(f & d);

endmodule

// File: rtl/nand_stim_seq.sv
// Sweeps all 16 input vectors through the NAND chain, holds each for HOLD_CYCLES,
// samples e/f/g against the golden model and reports one result word per vector.
module nand_stim_seq
   import nand_stim_seq_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             e,
   input  logic             f,
   input  logic             g,
   output logic [IDX_W-1:0] vec_idx,
   output logic             res_valid,
   output logic [7:0]       res_data,
   output logic [CNT_W-1:0] mism_cnt,
   output logic             busy,
   output logic             done
);

   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

   seq_state_e       state_q,   state_d;
   logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
   logic [IDX_W-1:0] vecIdx_q,  vecIdx_d;
   logic [CNT_W-1:0] mismCnt_q, mismCnt_d;
   res_word_t        resData_q, resData_d;

   logic goldE;
   logic goldF;
   logic goldG;
   logic isMismatch;

   nand_golden uGolden (
      .a (vecIdx_q[3]),
      .b (vecIdx_q[2]),
      .c (vecIdx_q[1]),
      .d (vecIdx_q[0]),
      .e (goldE),
      .f (goldF),
      .g (goldG)
   );

   assign isMismatch = ({e, f, g} != {goldE, goldF, goldG});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         holdCnt_q <= HOLD_RELOAD;
         vecIdx_q  <= '0;
         mismCnt_q <= '0;
         resData_q <= '0;
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
         vecIdx_q  <= vecIdx_d;
         mismCnt_q <= mismCnt_d;
         resData_q <= resData_d;
      end
   end

   // The driven vector is vecIdx_q itself, so a/b/c/d only move when a new DRIVE begins.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = holdCnt_q;
      vecIdx_d  = vecIdx_q;
      mismCnt_d = mismCnt_q;
      resData_d = resData_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_DRIVE;
               vecIdx_d  = '0;
               mismCnt_d = '0;
               holdCnt_d = HOLD_RELOAD;
            end
         end

         ST_DRIVE: begin
            if (holdCnt_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               holdCnt_d = holdCnt_q - 1'b1;
            end
         end

         ST_SAMPLE: begin
            state_d            = ST_REPORT;
            resData_d.vecIdx   = vecIdx_q;
            resData_d.efg      = {e, f, g};
            resData_d.mismatch = isMismatch;
            if (isMismatch && (mismCnt_q != MISM_MAX)) begin
               mismCnt_d = mismCnt_q + 1'b1;
            end
         end

         ST_REPORT: begin
            if (vecIdx_q == LAST_VEC) begin
               state_d = ST_DONE;
            end else if (step_mode) begin
               state_d = ST_WAIT_STEP;
            end else begin
               state_d   = ST_DRIVE;
               vecIdx_d  = vecIdx_q + 1'b1;
               holdCnt_d = HOLD_RELOAD;
            end
         end

         // Only step releases the pause; step_mode is not consulted here.
         ST_WAIT_STEP: begin
            if (step) begin
               state_d   = ST_DRIVE;
               vecIdx_d  = vecIdx_q + 1'b1;
               holdCnt_d = HOLD_RELOAD;
            end
         end

         ST_DONE: begin
            if (start) begin
               state_d   = ST_DRIVE;
               vecIdx_d  = '0;
               mismCnt_d = '0;
               holdCnt_d = HOLD_RELOAD;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign a         = vecIdx_q[3];
   assign b         = vecIdx_q[2];
   assign c         = vecIdx_q[1];
   assign d         = vecIdx_q[0];
   assign vec_idx   = vecIdx_q;
   assign res_valid = (state_q == ST_REPORT);
   assign res_data  = resData_q;
   assign mism_cnt  = mismCnt_q;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_nand_stim_seq.sv
// Randomised self-checking bench for nand_stim_seq: two instances (hold 4 and hold 1)
// driven by a behavioural NAND chain with injectable faults and checked against a chain model.
module tb_nand_stim_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic startReq = 1'b0;
   logic stepMode = 1'b0;
   logic step = 1'b0;
   logic sel = 1'b0;

   logic       start4, a4, b4, c4, d4, resValid4, busy4, done4;
   logic [3:0] vecIdx4;
   logic [7:0] resData4;
   logic [4:0] mismCnt4;
   logic [2:0] efg4;

   logic       start1, a1, b1, c1, d1, resValid1, busy1, done1;
   logic [3:0] vecIdx1;
   logic [7:0] resData1;
   logic [4:0] mismCnt1;
   logic [2:0] efg1;

   logic [3:0] obsAbcd, obsIdx;
   logic       obsValid, obsBusy, obsDone;
   logic [7:0] obsData;
   logic [4:0] obsMism;

   logic [2:0] faultXor [16];
   logic       stuckG = 1'b0;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   assign start4 = startReq & ~sel;
   assign start1 = startReq & sel;

   nand_stim_seq #(.HOLD_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .step_mode(stepMode), .step(step),
      .a(a4), .b(b4), .c(c4), .d(d4), .e(efg4[2]), .f(efg4[1]), .g(efg4[0]),
      .vec_idx(vecIdx4), .res_valid(resValid4), .res_data(resData4),
      .mism_cnt(mismCnt4), .busy(busy4), .done(done4)
   );

   nand_stim_seq #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .step_mode(stepMode), .step(step),
      .a(a1), .b(b1), .c(c1), .d(d1), .e(efg1[2]), .f(efg1[1]), .g(efg1[0]),
      .vec_idx(vecIdx1), .res_valid(resValid1), .res_data(resData1),
      .mism_cnt(mismCnt1), .busy(busy1), .done(done1)
   );

   // Ideal chain response for a vector index, written straight from the NAND equations.
   function automatic logic [2:0] refChain(input logic [3:0] v);
      logic ee, ff, gg;
      ee = !(v[3] && v[2]);
      ff = !(ee && v[1]);
      gg = !(ff && v[0]);
      return {ee, ff, gg};
   endfunction

   // The chain under test: ideal response, optionally corrupted per vector or with g stuck low.
   always_comb begin
      efg4 = refChain({a4, b4, c4, d4}) ^ faultXor[{a4, b4, c4, d4}];
      if (stuckG) efg4[0] = 1'b0;
      efg1 = refChain({a1, b1, c1, d1}) ^ faultXor[{a1, b1, c1, d1}];
      if (stuckG) efg1[0] = 1'b0;
   end

   always_comb begin
      if (sel) begin
         obsAbcd = {a1, b1, c1, d1};
         obsIdx = vecIdx1;   obsValid = resValid1; obsData = resData1;
         obsMism = mismCnt1; obsBusy = busy1;      obsDone = done1;
      end else begin
         obsAbcd = {a4, b4, c4, d4};
         obsIdx = vecIdx4;   obsValid = resValid4; obsData = resData4;
         obsMism = mismCnt4; obsBusy = busy4;      obsDone = done4;
      end
   end

   function automatic logic [7:0] modelRes(input int v);
      logic [3:0] idx;
      logic [2:0] gold, seen;
      idx  = v[3:0];
      gold = refChain(idx);
      seen = gold ^ faultXor[idx];
      if (stuckG) seen[0] = 1'b0;
      return {idx, seen, (seen != gold)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit randomFaults);
      for (int v = 0; v < 16; v++) begin
         if (randomFaults && ($urandom_range(0, 2) == 0)) faultXor[v] = 3'($urandom_range(1, 7));
         else faultXor[v] = 3'b000;
      end
   endtask

   // One full sweep from a start pulse; run mode checks timing, step mode exercises pauses.
   task automatic runSweep(input bit useStep, input bit noisy);
      int hold, elapsed, lastValid, nextVec, expMism, pauseLen;
      logic [7:0] res;
      hold = sel ? 1 : 4;
      expMism = 0;
      for (int v = 0; v < 16; v++) begin
         res = modelRes(v);
         if (res[0]) expMism++;
      end
      if (expMism > 16) expMism = 16;
      stepMode = useStep;
      @(negedge clk); startReq = 1'b1;
      @(negedge clk); startReq = 1'b0;
      elapsed = 1; nextVec = 0; lastValid = 0;
      checkOutput("startVec", obsIdx, 0);
      checkOutput("startMism", obsMism, 0);
      checkOutput("startBusy", obsBusy, 1);
      while (!obsDone && elapsed < 3000) begin
         if (obsValid) begin
            checkOutput("resData", obsData, modelRes(nextVec));
            if (nextVec == 0) checkOutput("firstValid", elapsed, hold + 2);
            else if (!useStep) checkOutput("validGap", elapsed - lastValid, hold + 2);
            lastValid = elapsed;
            nextVec++;
            if (useStep && nextVec < 16) begin
               pauseLen = (nextVec == 1) ? 50 : $urandom_range(1, 6);
               @(negedge clk); elapsed++;
               if (nextVec == 3) stepMode = 1'b0;
               repeat (pauseLen) begin @(negedge clk); elapsed++; end
               checkOutput("pauseAbcd", obsAbcd, nextVec - 1);
               checkOutput("pauseBusy", obsBusy, 1);
               step = 1'b1;
               startReq = (nextVec == 5);
               @(negedge clk); elapsed++;
               step = 1'b0; startReq = 1'b0; stepMode = 1'b1;
               checkOutput("stepVec", obsIdx, nextVec);
               checkOutput("stepAbcd", obsAbcd, nextVec);
               continue;
            end
         end
         if (noisy) begin
            startReq = ($urandom_range(0, 5) == 0);
            step = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk); elapsed++;
         startReq = 1'b0; step = 1'b0;
      end
      checkOutput("doneSeen", obsDone, 1);
      checkOutput("vecCount", nextVec, 16);
      if (!useStep) checkOutput("doneTime", elapsed, 16 * (hold + 2) + 1);
      checkOutput("doneMism", obsMism, expMism);
      repeat (3) @(negedge clk);
      checkOutput("doneHold", {obsDone, obsBusy, obsIdx}, {1'b1, 1'b0, 4'd15});
      stepMode = 1'b0;
   endtask

   initial begin
      int waited, strobes;

      applyStimulus(1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset4", {obsAbcd, obsIdx, obsValid, obsData, obsMism, obsBusy, obsDone}, 0);
      sel = 1'b1; #1;
      checkOutput("reset1", {obsAbcd, obsIdx, obsValid, obsData, obsMism, obsBusy, obsDone}, 0);
      sel = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      $display("[TB] good chain, run mode, noisy start/step");
      runSweep(1'b0, 1'b1);

      $display("[TB] g stuck at 0, restart from DONE");
      stuckG = 1'b1;
      runSweep(1'b0, 1'b0);
      checkOutput("stuckMism", obsMism, 11);
      stuckG = 1'b0;

      $display("[TB] random faults, step mode");
      applyStimulus(1'b1);
      runSweep(1'b1, 1'b0);

      $display("[TB] reset during vector 7");
      for (int v = 0; v < 16; v++) faultXor[v] = 3'b001;
      @(negedge clk); startReq = 1'b1;
      @(negedge clk); startReq = 1'b0;
      waited = 0;
      while (obsIdx != 4'd7 && waited < 500) begin @(negedge clk); waited++; end
      checkOutput("reachVec7", obsIdx, 7);
      checkOutput("mismAt7", obsMism, 7);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      checkOutput("abortOut", {obsAbcd, obsIdx, obsValid, obsData, obsMism, obsBusy, obsDone}, 0);
      strobes = 0;
      repeat (20) begin
         @(negedge clk);
         if (obsValid) strobes++;
      end
      checkOutput("abortNoValid", strobes, 0);
      checkOutput("abortIdle", {obsBusy, obsDone}, 0);

      $display("[TB] reset and start together");
      rst_n = 1'b0; startReq = 1'b1;
      @(negedge clk); rst_n = 1'b1; startReq = 1'b0;
      checkOutput("resetWins", {obsBusy, obsIdx}, 0);
      @(negedge clk);
      checkOutput("resetWinsIdle", obsBusy, 0);

      $display("[TB] hold of one cycle, random faults");
      applyStimulus(1'b1);
      sel = 1'b1; #1;
      runSweep(1'b0, 1'b1);
      sel = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
